// File: rtl/wb_timer.sv
// Wishbone timer peripheral: prescaled up-counter with compare match, one-shot
// mode and a level interrupt. Single-transfer slave with a one-cycle ack.
module wb_timer #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int PRESC_W = 16
) (
    input  logic                wb_clk_i,
    input  logic                rst_ni,
    input  logic [ADDR_W-1:0]   wb_addr_i,
    input  logic [DATA_W-1:0]   wb_wdata_i,
    output logic [DATA_W-1:0]   wb_rdata_o,
    input  logic                wb_wr_en_i,
    input  logic [DATA_W/8-1:0] wb_byte_en_i,
    input  logic                wb_stb_i,
    input  logic                wb_cyc_i,
    output logic                wb_ack_o,
    output logic                irq_o
);

    localparam logic [2:0] OFF_CTRL   = 3'd0;
    localparam logic [2:0] OFF_PRESC  = 3'd1;
    localparam logic [2:0] OFF_CMP    = 3'd2;
    localparam logic [2:0] OFF_COUNT  = 3'd3;
    localparam logic [2:0] OFF_STATUS = 3'd4;

    logic               en_q, en_d;
    logic               oneshot_q, oneshot_d;
    logic               irq_en_q, irq_en_d;
    logic               match_q, match_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [PRESC_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [31:0]        cmp_q, cmp_d;
    logic [31:0]        count_q, count_d;
    logic               ack_q, ack_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;

    logic [DATA_W-1:0]  wmask;
    logic [DATA_W-1:0]  rd_mux;
    logic [2:0]         off;
    logic               acc, wr, wr_ctrl, clr, w1c, tick, hit;
    logic               unused_addr;

    genvar gi;
    generate
        for (gi = 0; gi < DATA_W / 8; gi++) begin : g_wmask
            assign wmask[8*gi +: 8] = {8{wb_byte_en_i[gi]}};
        end
    endgenerate

    function automatic logic [31:0] merge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [31:0] mask);
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    assign unused_addr = ^{wb_addr_i[ADDR_W-1:5], wb_addr_i[1:0]};
    assign off     = wb_addr_i[4:2];
    assign acc     = wb_cyc_i & wb_stb_i & ~ack_q;
    assign wr      = acc & wb_wr_en_i;
    // CTRL and STATUS bits all live in byte 0.
    assign wr_ctrl = wr & (off == OFF_CTRL) & wb_byte_en_i[0];
    assign clr     = wr_ctrl & wb_wdata_i[3];
    assign w1c     = wr & (off == OFF_STATUS) & wb_byte_en_i[0] & wb_wdata_i[0];
    assign tick    = en_q & (pre_cnt_q == presc_q) & ~clr;
    assign hit     = tick & (count_q == cmp_q);

    always_comb begin
        rd_mux = '0;
        case (off)
            OFF_CTRL:   rd_mux = {29'd0, irq_en_q, oneshot_q, en_q};
            OFF_PRESC:  rd_mux = 32'(presc_q);
            OFF_CMP:    rd_mux = cmp_q;
            OFF_COUNT:  rd_mux = count_q;
            OFF_STATUS: rd_mux = {31'd0, match_q};
            default:    rd_mux = '0;
        endcase
    end

    always_comb begin
        en_d      = en_q;
        oneshot_d = oneshot_q;
        irq_en_d  = irq_en_q;
        match_d   = match_q;
        presc_d   = presc_q;
        pre_cnt_d = pre_cnt_q;
        cmp_d     = cmp_q;
        count_d   = count_q;
        ack_d     = acc;
        rdata_d   = acc ? rd_mux : rdata_q;

        if (en_q)
            pre_cnt_d = (pre_cnt_q == presc_q) ? '0 : pre_cnt_q + 1'b1;
        if (tick)
            count_d = hit ? 32'd0 : count_q + 32'd1;
        if (clr) begin
            pre_cnt_d = '0;
            count_d   = '0;
        end
        if (wr && off == OFF_COUNT)
            count_d = merge(count_q, wb_wdata_i, wmask);

        // Hardware set wins over the software clear in the same edge.
        if (w1c)
            match_d = 1'b0;
        if (hit)
            match_d = 1'b1;

        if (hit && oneshot_q)
            en_d = 1'b0;
        if (wr_ctrl) begin
            en_d      = wb_wdata_i[0];
            oneshot_d = wb_wdata_i[1];
            irq_en_d  = wb_wdata_i[2];
        end

        if (wr && off == OFF_PRESC)
            presc_d = PRESC_W'(merge(32'(presc_q), wb_wdata_i, wmask));
        if (wr && off == OFF_CMP)
            cmp_d = merge(cmp_q, wb_wdata_i, wmask);
    end

    always_ff @(posedge wb_clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            en_q      <= 1'b0;
            oneshot_q <= 1'b0;
            irq_en_q  <= 1'b0;
            match_q   <= 1'b0;
            presc_q   <= '0;
            pre_cnt_q <= '0;
            cmp_q     <= '0;
            count_q   <= '0;
            ack_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            en_q      <= en_d;
            oneshot_q <= oneshot_d;
            irq_en_q  <= irq_en_d;
            match_q   <= match_d;
            presc_q   <= presc_d;
            pre_cnt_q <= pre_cnt_d;
            cmp_q     <= cmp_d;
            count_q   <= count_d;
            ack_q     <= ack_d;
            rdata_q   <= rdata_d;
        end
    end

    assign wb_ack_o   = ack_q;
    assign wb_rdata_o = rdata_q;
    assign irq_o      = match_q & irq_en_q;

endmodule

// File: doc/wb_timer.md
Name: wb_timer

Overview:
Wishbone slave timer peripheral that sits directly downstream of the OBI-to-Wishbone bridge. It consumes the bridge's single-transfer Wishbone cycles. It provides a prescaled up-counter with a compare match, an auto-reload/one-shot mode and a level interrupt to the core. All logic runs in the Wishbone clock domain.

Parameters:
ADDR_W, 32, Wishbone address width; only bits [4:2] are decoded.
DATA_W, 32, data width; must be 32.
PRESC_W, 16, prescaler register width (PRESC_W <= 32).

Ports:
wb_clk_i  in  1  single clock; all state on rising edge.
rst_ni  in  1  reset, asynchronous, active-low.
wb_addr_i  in  ADDR_W  byte address; word offset is addr[4:2].
wb_wdata_i  in  DATA_W  write data.
wb_rdata_o  out  DATA_W  read data, valid while wb_ack_o=1.
wb_wr_en_i  in  1  1 = write, 0 = read.
wb_byte_en_i  in  DATA_W/8  per-byte write enable.
wb_stb_i  in  1  strobe.
wb_cyc_i  in  1  cycle.
wb_ack_o  out  1  one-cycle acknowledge.
irq_o  out  1  level interrupt = STATUS.MATCH & CTRL.IRQ_EN.

Behaviour:
- Reset (asynchronous, rst_ni=0): all registers and counters 0, so CTRL=0, PRESC=0, CMP=0, COUNT=0 and STATUS=0. wb_ack_o=0, wb_rdata_o=0, irq_o=0. A reset mid-transfer drops ack; the pending transfer is lost.
- Bus handshake:
  - A request is accepted when cyc & stb & ~wb_ack_o at a clock edge.
  - At that edge wb_ack_o<=1, the write is committed, and wb_rdata_o is loaded.
  - The next edge forces wb_ack_o<=0, so the ack is exactly one cycle and there is one wait state.
  - The idle-to-request-to-ack throughput is one transfer per 2 cycles minimum.
  - If stb or cyc falls before acceptance, nothing happens.
  - Every access is acked, including unmapped offsets and writes to read-only fields. There is no error signalling.
- Byte enables: a write updates only the bytes whose wb_byte_en_i bit is 1. Bits beyond a field's width are ignored on write and read as 0.
- Register map (word offset; address):
  - 0 (0x00) CTRL: bit0 EN, bit1 ONESHOT, bit2 IRQ_EN, bit3 CLR. CLR is write-1 and self-clearing; it always reads 0.
  - 1 (0x04) PRESC: [PRESC_W-1:0], read/write.
  - 2 (0x08) CMP: [31:0], read/write.
  - 3 (0x0C) COUNT: [31:0], read/write.
  - 4 (0x10) STATUS: bit0 MATCH, write-1-to-clear.
  - 5..7: read 0, writes ignored.
- Prescaler (internal pre_cnt, PRESC_W bits), active while EN=1:
  - Each cycle: if pre_cnt==PRESC, then pre_cnt<=0 and tick=1; otherwise pre_cnt<=pre_cnt+1.
  - With PRESC=0, tick occurs every cycle; in general a tick occurs every PRESC+1 cycles.
  - EN=0 freezes pre_cnt and COUNT.
- Counter on tick:
  - If COUNT==CMP: COUNT<=0 and MATCH<=1. If ONESHOT=1, EN<=0 in the same edge.
  - Otherwise COUNT<=COUNT+1, wrapping 0xFFFF_FFFF to 0 with no flag.
- CLR written as 1: pre_cnt<=0 and COUNT<=0 in the commit edge. The other CTRL bits take the written values in the same edge.
- Simultaneous events, priority in decreasing order:
  - A bus write to COUNT overrides the tick update of COUNT.
  - CLR overrides a tick in the same edge.
  - A hardware MATCH set overrides a W1C clear of STATUS in the same edge, so MATCH stays 1.
  - A bus write of CTRL.EN overrides the ONESHOT auto-clear of EN in the same edge.
  - A write to PRESC does not reset pre_cnt. If the new PRESC < pre_cnt, pre_cnt counts up, wraps at 2^PRESC_W, and then matches.
- Read data: wb_rdata_o captures the register value before the commit-edge update. A read of COUNT returns the pre-tick value of that edge.
- irq_o is combinational from registered MATCH and IRQ_EN, so it is glitch-free.

Test Plan:
1. Reset, then read all offsets 0x00-0x1C -> every read returns 0; each ack is one cycle, asserted on the edge after stb/cyc rise.
2. Write PRESC=3, CMP=4, CTRL=0x5 -> COUNT steps every 4 cycles (0,1,2,3,4,0); MATCH=1 and irq_o=1 after 20 cycles; writing STATUS=1 clears irq_o.
3. Write CMP=2, PRESC=0, CTRL=0x3 (one-shot) -> COUNT goes 0,1,2,0, then EN reads 0 and COUNT holds 0; MATCH=1 and irq_o=0 because IRQ_EN=0.
4. Write COUNT=0xFFFF_FFFE, CMP=5, PRESC=0, CTRL=1 -> COUNT goes 0xFFFF_FFFF, 0, 1; no MATCH at the wrap.
5. Byte-enable write: CMP=0x1122_3344, then write 0xAABB_CCDD with byte_en=4'b0101 -> CMP reads 0x11BB_33DD; a write to 0x18 is acked and reads 0.
6. Collision cases:
   - W1C STATUS in the same edge as a match tick -> MATCH stays 1.
   - COUNT write of 0x10 in a tick edge -> COUNT=0x10.
   - rst_ni pulsed low while stb=1 -> ack never asserts; all registers read 0 after reset.
